// File: rtl/sga_snake_body_fd.sv
// ---------------------------------------------------------------------------
// sga_snake_body_fd
//
// Snake-body datapath for the Snake Game Arcade. Segment cells live in a
// circular buffer indexed by head_ptr. Each accepted step advances the head by
// one cell. The snake grows one step after it eats the apple. Wall and self
// collisions are detected and latched until reset or restart. A small render
// FSM scans the body one segment per cycle, head first, and publishes a
// double-buffered LED frame that includes the apple.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-high clear
//   restart       in   synchronous clear (same effect as reset)
//   step          in   one-cycle pulse: move one cell in direction dir
//   dir           in   00 right, 01 left, 10 up, 11 down
//   apple_pos     in   current apple cell (row*GRID_W + col)
//   render_start  in   one-cycle pulse: start a frame scan
//   head_pos      out  current head cell
//   length        out  current number of segments
//   ate_apple     out  one-cycle pulse: the accepted step landed on the apple
//   hit_wall      out  sticky: a step tried to leave the grid
//   hit_self      out  sticky: a step ran into the body
//   render_busy   out  high while a scan (SCAN or DONE) is in progress
//   render_valid  out  render_pos carries a segment cell this cycle
//   render_pos    out  segment cell being scanned
//   render_done   out  one-cycle pulse at the end of a scan
//   leds          out  frame buffer, bit k = cell k lit
// ---------------------------------------------------------------------------
module sga_snake_body_fd #(
  parameter int GRID_W   = 6,
  parameter int GRID_H   = 6,
  parameter int MAX_LEN  = 16,
  parameter int INIT_POS = 14,
  localparam int CELLS   = GRID_W * GRID_H,
  localparam int POS_W   = $clog2(CELLS),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             step,
  input  logic [1:0]       dir,
  input  logic [POS_W-1:0] apple_pos,
  input  logic             render_start,
  output logic [POS_W-1:0] head_pos,
  output logic [LEN_W-1:0] length,
  output logic             ate_apple,
  output logic             hit_wall,
  output logic             hit_self,
  output logic             render_busy,
  output logic             render_valid,
  output logic [POS_W-1:0] render_pos,
  output logic             render_done,
  output logic [CELLS-1:0] leds
);

  localparam int PTR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int INIT_ROW = INIT_POS / GRID_W;
  localparam int INIT_COL = INIT_POS % GRID_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [POS_W-1:0] body [MAX_LEN];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [POS_W-1:0] head_row;
  logic [POS_W-1:0] head_col;
  logic             grow_pending;
  logic [LEN_W-1:0] idx;
  logic [CELLS-1:0] scratch;

  logic [POS_W-1:0] next_head;
  logic [POS_W-1:0] next_row;
  logic [POS_W-1:0] next_col;
  logic             off_grid;
  logic             self_hit;
  logic             game_over;
  logic             step_ok;
  logic             start_ok;
  int               self_age;
  int               self_limit;
  int               rd_calc;

  assign game_over = hit_wall | hit_self;
  assign step_ok   = (state == S_IDLE) && step && !game_over;
  // A step in the same cycle as render_start takes priority; the start is dropped.
  assign start_ok  = (state == S_IDLE) && render_start && !step;
  assign ptr_nxt   = (head_ptr == LAST_PTR) ? '0 : head_ptr + 1'b1;

  // Candidate head cell; row/col are tracked alongside head_pos so no
  // divider is needed to find the grid edges.
  always_comb begin
    next_head = head_pos;
    next_row  = head_row;
    next_col  = head_col;
    off_grid  = 1'b0;
    case (dir)
      2'b00: begin
        if (head_col == POS_W'(GRID_W - 1)) off_grid = 1'b1;
        else begin
          next_col  = head_col + 1'b1;
          next_head = head_pos + 1'b1;
        end
      end
      2'b01: begin
        if (head_col == '0) off_grid = 1'b1;
        else begin
          next_col  = head_col - 1'b1;
          next_head = head_pos - 1'b1;
        end
      end
      2'b10: begin
        if (head_row == '0) off_grid = 1'b1;
        else begin
          next_row  = head_row - 1'b1;
          next_head = head_pos - POS_W'(GRID_W);
        end
      end
      default: begin
        if (head_row == POS_W'(GRID_H - 1)) off_grid = 1'b1;
        else begin
          next_row  = head_row + 1'b1;
          next_head = head_pos + POS_W'(GRID_W);
        end
      end
    endcase
  end

  // Self collision: a buffer slot is part of the body when its age (distance
  // behind the head) is below the live length. The tail is left out when no
  // growth is pending because it moves away on this very step.
  always_comb begin
    self_hit   = 1'b0;
    self_age   = 0;
    self_limit = grow_pending ? int'(length) : int'(length) - 1;
    for (int j = 0; j < MAX_LEN; j++) begin
      self_age = int'(head_ptr) - j;
      if (self_age < 0) self_age = self_age + MAX_LEN;
      if ((self_age < self_limit) && (body[j] == next_head)) self_hit = 1'b1;
    end
  end

  // Scan read pointer walks backwards from the head, wrapping explicitly so
  // MAX_LEN need not be a power of two.
  always_comb begin
    rd_calc = int'(head_ptr) - int'(idx);
    if (rd_calc < 0) rd_calc = rd_calc + MAX_LEN;
    rd_ptr = PTR_W'(rd_calc);
  end

  // Render FSM: state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        state <= S_IDLE;
    else if (restart) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Render FSM: next state. SCAN covers exactly `length` cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_SCAN;
      S_SCAN:  if (idx == length - 1'b1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Render FSM: outputs. render_valid is a strobe with no back-pressure:
  // whenever it is high, render_pos holds a body cell (head first, tail last)
  // and the consumer must take it in that cycle.
  always_comb begin
    render_busy  = (state == S_SCAN) || (state == S_DONE);
    render_valid = (state == S_SCAN);
    render_done  = (state == S_DONE);
    render_pos   = (state == S_SCAN) ? body[rd_ptr] : '0;
  end

  // Snake datapath and frame buffers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= (i == 0) ? POS_W'(INIT_POS) : '0;
      head_ptr     <= '0;
      head_pos     <= POS_W'(INIT_POS);
      head_row     <= POS_W'(INIT_ROW);
      head_col     <= POS_W'(INIT_COL);
      length       <= LEN_W'(1);
      grow_pending <= 1'b0;
      ate_apple    <= 1'b0;
      hit_wall     <= 1'b0;
      hit_self     <= 1'b0;
      idx          <= '0;
      scratch      <= '0;
      leds         <= '0;
    end else if (restart) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= (i == 0) ? POS_W'(INIT_POS) : '0;
      head_ptr     <= '0;
      head_pos     <= POS_W'(INIT_POS);
      head_row     <= POS_W'(INIT_ROW);
      head_col     <= POS_W'(INIT_COL);
      length       <= LEN_W'(1);
      grow_pending <= 1'b0;
      ate_apple    <= 1'b0;
      hit_wall     <= 1'b0;
      hit_self     <= 1'b0;
      idx          <= '0;
      scratch      <= '0;
      leds         <= '0;
    end else begin
      ate_apple <= 1'b0;

      if (step_ok) begin
        if (off_grid) begin
          hit_wall <= 1'b1;
        end else if (self_hit) begin
          hit_self <= 1'b1;
        end else begin
          head_ptr       <= ptr_nxt;
          body[ptr_nxt]  <= next_head;
          head_pos       <= next_head;
          head_row       <= next_row;
          head_col       <= next_col;
          // Growth from the previous meal is applied now; at full length the
          // head overwrites the tail slot and the pending growth is lost.
          if (grow_pending && (length < LEN_W'(MAX_LEN))) length <= length + 1'b1;
          grow_pending   <= (next_head == apple_pos);
          ate_apple      <= (next_head == apple_pos);
        end
      end

      if (start_ok) begin
        idx     <= '0;
        scratch <= '0;
      end else if (state == S_SCAN) begin
        idx     <= idx + 1'b1;
        scratch <= scratch | (CELLS'(1) << render_pos);
      end

      // leds is only published once the scan has completed.
      if (state == S_DONE) leds <= scratch | (CELLS'(1) << apple_pos);
    end
  end

endmodule

// File: tb/tb_sga_snake_body_fd.sv
// ---------------------------------------------------------------------------
// tb_sga_snake_body_fd
//
// Directed bench for sga_snake_body_fd. A behavioural snake model (a queue of
// cells, head at index 0) predicts head position, length, collisions and the
// render order; predicted cells are queued when stimulus is driven and popped
// when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_sga_snake_body_fd;

  localparam int GRID_W   = 6;
  localparam int GRID_H   = 6;
  localparam int MAX_LEN  = 16;
  localparam int INIT_POS = 14;
  localparam int CELLS    = GRID_W * GRID_H;
  localparam int POS_W    = $clog2(CELLS);
  localparam int LEN_W    = $clog2(MAX_LEN + 1);

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] L = 2'b01;
  localparam logic [1:0] U = 2'b10;
  localparam logic [1:0] D = 2'b11;

  logic             clock = 1'b0;
  logic             reset;
  logic             restart;
  logic             step;
  logic [1:0]       dir;
  logic [POS_W-1:0] apple_pos;
  logic             render_start;
  logic [POS_W-1:0] head_pos;
  logic [LEN_W-1:0] length;
  logic             ate_apple;
  logic             hit_wall;
  logic             hit_self;
  logic             render_busy;
  logic             render_valid;
  logic [POS_W-1:0] render_pos;
  logic             render_done;
  logic [CELLS-1:0] leds;

  sga_snake_body_fd #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MAX_LEN (MAX_LEN),
    .INIT_POS(INIT_POS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .restart     (restart),
    .step        (step),
    .dir         (dir),
    .apple_pos   (apple_pos),
    .render_start(render_start),
    .head_pos    (head_pos),
    .length      (length),
    .ate_apple   (ate_apple),
    .hit_wall    (hit_wall),
    .hit_self    (hit_self),
    .render_busy (render_busy),
    .render_valid(render_valid),
    .render_pos  (render_pos),
    .render_done (render_done),
    .leds        (leds)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [POS_W-1:0] exp_q[$];
  int               body_m[$];
  bit               gp_m;
  bit               wall_m;
  bit               self_m;
  logic [CELLS-1:0] leds_m;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    body_m.delete();
    body_m.push_back(INIT_POS);
    gp_m   = 1'b0;
    wall_m = 1'b0;
    self_m = 1'b0;
    leds_m = '0;
  endtask

  function automatic int next_cell(input int h, input logic [1:0] d, output bit off);
    int r;
    int c;
    r   = h / GRID_W;
    c   = h % GRID_W;
    off = 1'b0;
    case (d)
      R: if (c == GRID_W - 1) off = 1'b1; else c = c + 1;
      L: if (c == 0) off = 1'b1; else c = c - 1;
      U: if (r == 0) off = 1'b1; else r = r - 1;
      default: if (r == GRID_H - 1) off = 1'b1; else r = r + 1;
    endcase
    return r * GRID_W + c;
  endfunction

  // Driver: one step. When eat is set the apple is placed on the target cell.
  task automatic do_step(input logic [1:0] d, input bit eat, input string tag);
    int nh;
    int lim;
    bit off;
    bit hit;
    bit ate;
    nh  = next_cell(body_m[0], d, off);
    ate = 1'b0;
    if (eat && !off) apple_pos = POS_W'(nh);
    if (!(wall_m || self_m)) begin
      if (off) wall_m = 1'b1;
      else begin
        lim = gp_m ? body_m.size() : body_m.size() - 1;
        hit = 1'b0;
        for (int i = 0; i < lim; i++) if (body_m[i] == nh) hit = 1'b1;
        if (hit) self_m = 1'b1;
        else begin
          body_m.push_front(nh);
          if (!gp_m || body_m.size() > MAX_LEN) void'(body_m.pop_back());
          ate  = (nh == int'(apple_pos));
          gp_m = ate;
        end
      end
    end
    exp_q.push_back(POS_W'(body_m[0]));
    dir  = d;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk({tag, "_head"}, head_pos, exp_q.pop_front());
    chk({tag, "_len"},  length,   body_m.size());
    chk({tag, "_ate"},  ate_apple, ate);
    chk({tag, "_wall"}, hit_wall,  wall_m);
    chk({tag, "_self"}, hit_self,  self_m);
  endtask

  // Driver: one full frame scan, compared cell by cell against the model.
  task automatic do_render(input string tag);
    logic [CELLS-1:0] mask;
    int  nvalid;
    int  done_at;
    bit  done_seen;
    mask = '0;
    foreach (body_m[i]) begin
      exp_q.push_back(POS_W'(body_m[i]));
      mask[body_m[i]] = 1'b1;
    end
    if (int'(apple_pos) < CELLS) mask[apple_pos] = 1'b1;
    render_start = 1'b1;
    tick();
    render_start = 1'b0;
    chk({tag, "_busy"}, render_busy, 1'b1);
    nvalid    = 0;
    done_at   = -1;
    done_seen = 1'b0;
    for (int c = 0; c < MAX_LEN + 4 && !done_seen; c++) begin
      if (render_valid) begin
        if (exp_q.size() > 0) chk({tag, "_pos"}, render_pos, exp_q.pop_front());
        else chk({tag, "_extra_valid"}, render_valid, 1'b0);
        nvalid++;
      end
      if (render_done) begin
        done_seen = 1'b1;
        done_at   = c;
        chk({tag, "_leds_hold"}, leds, leds_m);
      end else begin
        tick();
      end
    end
    chk({tag, "_done_seen"}, done_seen, 1'b1);
    chk({tag, "_done_cycle"}, done_at, body_m.size());
    chk({tag, "_nvalid"}, nvalid, body_m.size());
    chk({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    tick();
    leds_m = mask;
    chk({tag, "_leds"}, leds, leds_m);
    chk({tag, "_done_clr"}, render_done, 1'b0);
    chk({tag, "_idle"}, render_busy, 1'b0);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_clear();
    chk({tag, "_head"}, head_pos, INIT_POS);
    chk({tag, "_len"},  length, 1);
    chk({tag, "_wall"}, hit_wall, 1'b0);
    chk({tag, "_self"}, hit_self, 1'b0);
    chk({tag, "_leds"}, leds, '0);
    chk({tag, "_busy"}, render_busy, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    restart      = 1'b0;
    step         = 1'b0;
    dir          = 2'b00;
    apple_pos    = POS_W'(35);
    render_start = 1'b0;
    model_clear();

    // Reset state
    #12;
    chk("rst_head",  head_pos, INIT_POS);
    chk("rst_len",   length, 1);
    chk("rst_ate",   ate_apple, 1'b0);
    chk("rst_wall",  hit_wall, 1'b0);
    chk("rst_self",  hit_self, 1'b0);
    chk("rst_leds",  leds, '0);
    chk("rst_busy",  render_busy, 1'b0);
    chk("rst_valid", render_valid, 1'b0);
    chk("rst_pos",   render_pos, '0);
    chk("rst_done",  render_done, 1'b0);
    reset = 1'b0;
    tick();

    // Plain moves to the right
    do_step(R, 1'b0, "t1_a");
    do_step(R, 1'b0, "t1_b");
    do_step(R, 1'b0, "t1_c");
    chk("t1_head17", head_pos, 17);
    chk("t1_len1", length, 1);

    // Wall at column 5, then a step that must be ignored
    do_step(R, 1'b0, "t3_wall");
    chk("t3_wall_set", hit_wall, 1'b1);
    do_step(D, 1'b0, "t3_ignored");
    chk("t3_head_kept", head_pos, 17);
    do_restart("t3_restart");

    // Eat, then grow on the following step
    do_step(R, 1'b1, "t2_eat");
    tick();
    chk("t2_ate_pulse", ate_apple, 1'b0);
    apple_pos = POS_W'(35);
    do_step(R, 1'b0, "t2_grow");
    chk("t2_len2", length, 2);
    chk("t2_head16", head_pos, 16);

    // step and render_start together: the step wins
    render_start = 1'b1;
    do_step(D, 1'b1, "coll_step");
    render_start = 1'b0;
    chk("coll_no_scan", render_busy, 1'b0);
    do_step(D, 1'b0, "t5_grow");
    chk("t5_len3", length, 3);

    // Frame scan of a length-3 snake
    apple_pos = POS_W'(0);
    do_render("t5");
    chk("t5_leds_const", leds, (CELLS'(1) << 28) | (CELLS'(1) << 22) | (CELLS'(1) << 16) | CELLS'(1));

    // Step during a scan is ignored; restart aborts the scan silently
    render_start = 1'b1;
    tick();
    render_start = 1'b0;
    dir  = R;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("abort_step_ignored", head_pos, 28);
    chk("abort_scanning", render_valid, 1'b1);
    do_restart("abort");
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_done", render_done, 1'b0);
      tick();
    end

    // U shape of length 5, then step into the neck
    do_step(R, 1'b1, "t4_a");
    do_step(R, 1'b1, "t4_b");
    do_step(D, 1'b1, "t4_c");
    do_step(L, 1'b1, "t4_d");
    do_step(L, 1'b0, "t4_e");
    chk("t4_len5", length, 5);
    do_step(R, 1'b0, "t4_neck");
    chk("t4_hit_self", hit_self, 1'b1);
    chk("t4_head20", head_pos, 20);
    do_render("t4_gameover");

    // Moving into the vacating tail cell is legal
    do_restart("t4_restart");
    do_step(R, 1'b1, "tail_a");
    do_step(R, 1'b1, "tail_b");
    do_step(D, 1'b1, "tail_c");
    do_step(L, 1'b0, "tail_d");
    do_step(U, 1'b0, "tail_move");
    chk("tail_no_self", hit_self, 1'b0);
    chk("tail_head15", head_pos, 15);

    // Grow to full length across the buffer wrap, eating every step
    do_restart("t6_restart");
    begin
      logic [1:0] path [21];
      path = '{R, R, R, D, L, L, L, L, L, D, R, R, R, R, R, D, L, L, L, L, L};
      foreach (path[i]) do_step(path[i], 1'b1, "t6_step");
    end
    chk("t6_len_max", length, MAX_LEN);
    chk("t6_head30", head_pos, 30);
    do_render("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
